// File: rtl/burst_pulse_gen_if.sv
// ----------------------------------------------------------------------------
// burst_pulse_gen_if
//
// Purpose: bundles the control, operand and status signals of the pulse-burst
// generator so the block and its driver share one declaration.
//
// Signals:
//   start_in      - burst request, honoured only when the generator is idle
//   abort_in      - terminates any burst immediately (synchronous)
//   num_pulses_in - pulses per burst (NW bits), latched on accept
//   period_in     - cycles per pulse (PW bits), latched on accept
//   high_in       - high cycles per pulse (PW bits), latched on accept
//   pulse_out     - registered excitation waveform
//   evt_out       - one-cycle strobe on the first high cycle of each pulse
//   busy_out      - high for every cycle of an accepted burst
//   done_out      - one-cycle strobe after a burst ends normally
//   pulse_idx_out - pulses emitted so far in the current burst (NW bits)
//
// Modports:
//   master - the requester: drives requests and operands, observes status
//   slave  - the generator itself
// ----------------------------------------------------------------------------
interface burst_pulse_gen_if #(
    parameter int unsigned MAX_PULSES = 256,
    parameter int unsigned MAX_PERIOD = 65536
);
    localparam int unsigned NW = $clog2(MAX_PULSES);
    localparam int unsigned PW = $clog2(MAX_PERIOD);

    logic          start_in;
    logic          abort_in;
    logic [NW-1:0] num_pulses_in;
    logic [PW-1:0] period_in;
    logic [PW-1:0] high_in;
    logic          pulse_out;
    logic          evt_out;
    logic          busy_out;
    logic          done_out;
    logic [NW-1:0] pulse_idx_out;

    modport master (
        output start_in,
        output abort_in,
        output num_pulses_in,
        output period_in,
        output high_in,
        input  pulse_out,
        input  evt_out,
        input  busy_out,
        input  done_out,
        input  pulse_idx_out
    );

    modport slave (
        input  start_in,
        input  abort_in,
        input  num_pulses_in,
        input  period_in,
        input  high_in,
        output pulse_out,
        output evt_out,
        output busy_out,
        output done_out,
        output pulse_idx_out
    );
endinterface

// File: rtl/burst_pulse_gen.sv
// ----------------------------------------------------------------------------
// burst_pulse_gen
//
// Purpose: programmable pulse-burst generator for the transducer excitation
// path. A start request in IDLE latches a pulse count N, a period P and a high
// time H, then emits N rectangular pulses of P cycles each (H cycles high),
// with a one-cycle event strobe on the first high cycle of every pulse. A
// one-cycle done strobe follows a normally completed burst and opens the
// echo-timing window downstream.
//
// Ports:
//   clk_in  - single clock, all logic on its rising edge
//   rst_in  - asynchronous active-high reset, clears every output at once
//   bus     - burst_pulse_gen_if.slave: start/abort requests, the three
//             operands, and the registered status outputs
//
// Parameters:
//   MAX_PULSES - power of 2; burst length field is $clog2(MAX_PULSES) bits
//   MAX_PERIOD - power of 2; period/high field is $clog2(MAX_PERIOD) bits
// ----------------------------------------------------------------------------
module burst_pulse_gen #(
    parameter int unsigned MAX_PULSES = 256,
    parameter int unsigned MAX_PERIOD = 65536
) (
    input  logic               clk_in,
    input  logic               rst_in,
    burst_pulse_gen_if.slave   bus
);
    localparam int unsigned NW = $clog2(MAX_PULSES);
    localparam int unsigned PW = $clog2(MAX_PERIOD);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and latched operands
    // ------------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [PW-1:0] r_period;    // effective period P (>= 2)
    logic [PW-1:0] r_high;      // effective high time H (1..P-1)
    logic [NW-1:0] r_num;       // latched pulse count N
    logic [NW-1:0] r_cnt;       // pulses started so far, 1..N while running
    logic [PW-1:0] r_phase;     // position inside the current pulse
    logic [NW-1:0] r_idx;
    logic          r_pulse;
    logic          r_evt;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic [PW-1:0] w_period_nxt;
    logic [PW-1:0] w_high_nxt;
    logic [NW-1:0] w_num_nxt;
    logic [NW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_phase_nxt;
    logic [NW-1:0] w_idx_nxt;
    logic          w_pulse_nxt;
    logic          w_evt_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // ------------------------------------------------------------------------
    // Operand clamps, evaluated on the raw inputs so they can be latched as-is
    // ------------------------------------------------------------------------
    logic [PW-1:0] w_period_eff;
    logic [PW-1:0] w_high_eff;

    always_comb begin
        // A pulse needs at least one high and one low cycle, so P >= 2.
        if (bus.period_in < PW'(2)) begin
            w_period_eff = PW'(2);
        end else begin
            w_period_eff = bus.period_in;
        end

        if (bus.high_in == '0) begin
            w_high_eff = PW'(1);
        end else if (bus.high_in >= w_period_eff) begin
            w_high_eff = w_period_eff - PW'(1);
        end else begin
            w_high_eff = bus.high_in;
        end
    end

    // ------------------------------------------------------------------------
    // Phase bookkeeping
    // ------------------------------------------------------------------------
    logic [PW-1:0] w_phase_inc;
    logic          w_last_phase;
    logic          w_last_pulse;

    always_comb begin
        w_phase_inc  = r_phase + PW'(1);
        w_last_phase = (r_phase == (r_period - PW'(1)));
        w_last_pulse = (r_cnt == r_num);
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Outputs are computed one cycle ahead so that every
    // output is a flop and nothing combinational reaches the pins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_num_nxt    = r_num;
        w_cnt_nxt    = r_cnt;
        w_phase_nxt  = r_phase;
        w_idx_nxt    = r_idx;
        w_pulse_nxt  = 1'b0;
        w_evt_nxt    = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        if (bus.abort_in) begin
            // Abort wins over everything, including a same-cycle start. The
            // pulse index is deliberately frozen for post-mortem inspection.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        w_period_nxt = w_period_eff;
                        w_high_nxt   = w_high_eff;
                        w_num_nxt    = bus.num_pulses_in;
                        w_idx_nxt    = '0;
                        w_phase_nxt  = '0;
                        if (bus.num_pulses_in == '0) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            // First pulse begins right away: H >= 1 makes its
                            // first cycle high.
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = NW'(1);
                            w_pulse_nxt = 1'b1;
                            w_evt_nxt   = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // Index lags the event strobe by one cycle.
                    if (r_evt && (r_idx != r_num)) begin
                        w_idx_nxt = r_idx + NW'(1);
                    end

                    if (w_last_phase) begin
                        if (w_last_pulse) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_phase_nxt = '0;
                            w_cnt_nxt   = r_cnt + NW'(1);
                            w_pulse_nxt = 1'b1;
                            w_evt_nxt   = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = w_phase_inc;
                        w_pulse_nxt = (w_phase_inc < r_high);
                        w_busy_nxt  = 1'b1;
                    end
                end

                ST_DONE: begin
                    // Start requests here are dropped, not queued.
                    w_state_nxt = ST_IDLE;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_period <= PW'(2);
            r_high   <= PW'(1);
            r_num    <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_idx    <= '0;
            r_pulse  <= 1'b0;
            r_evt    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_num    <= w_num_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_idx    <= w_idx_nxt;
            r_pulse  <= w_pulse_nxt;
            r_evt    <= w_evt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight from flops
    // ------------------------------------------------------------------------
    assign bus.pulse_out     = r_pulse;
    assign bus.evt_out       = r_evt;
    assign bus.busy_out      = r_busy;
    assign bus.done_out      = r_done;
    assign bus.pulse_idx_out = r_idx;

endmodule
